// File: rtl/nec_ir_receiver.sv
// nec_ir_receiver
// Decodes a demodulated NEC infrared stream (idle high, carrier burst = low)
// into a 32-bit code. Mark and space lengths are measured in prescaled ticks
// and each one is validated against the NEC timing windows before it is used.
//
// Ports:
//   clk_in      system (pixel) clock
//   rst_in      asynchronous active-low reset
//   ir_raw_in   raw IR sensor output, asynchronous to clk_in
//   code_out    last accepted frame, first received bit in bit 31
//   valid_out   one-cycle pulse when code_out is updated
//   repeat_out  one-cycle pulse on a valid repeat frame (only once a code is held)
//   err_out     one-cycle pulse on a timing violation, timeout or integrity failure
//   busy_out    high while a frame is being received
//
// Optional feature:
//   NEC_INTEGRITY_CHECK_EN - when defined, a frame is accepted only if its
//   low byte is the bitwise inverse of the byte above it; otherwise err_out
//   pulses and code_out keeps its old value.

module nec_ir_receiver #(
   parameter int TICK_CYCLES   = 742,
   parameter int TIMEOUT_TICKS = 1200
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        ir_raw_in,
   output logic [31:0] code_out,
   output logic        valid_out,
   output logic        repeat_out,
   output logic        err_out,
   output logic        busy_out
);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      REP_MARK
   } state_t;

   localparam int          PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
   localparam logic [10:0] DUR_MAX    = 11'd2047;
   localparam logic [10:0] TIMEOUT    = 11'(TIMEOUT_TICKS);

   state_t        state_q, state_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          prev_q, prev_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [10:0]   dur_q, dur_d;
   logic [31:0]   shift_q, shift_d;
   logic [5:0]    bit_cnt_q, bit_cnt_d;
   logic [31:0]   code_q, code_d;
   logic          have_q, have_d;
   logic          valid_q, valid_d;
   logic          repeat_q, repeat_d;
   logic          err_q, err_d;

   logic          fall, rise, edge_seen, tick;
   logic          frame_err, frame_done;

   function automatic logic in_win(input logic [10:0] d, input logic [10:0] lo,
                                   input logic [10:0] hi);
      return (d >= lo) && (d <= hi);
   endfunction

   // Synchronizer and edge register; all reset to the idle-high level so that
   // releasing reset with the line idle never looks like a mark start.
   assign sync1_d   = ir_raw_in;
   assign sync2_d   = sync1_q;
   assign prev_d    = sync2_q;
   assign fall      = prev_q & ~sync2_q;
   assign rise      = ~prev_q & sync2_q;
   assign edge_seen = fall | rise;
   assign tick      = (presc_q == PRESC_MAX);

   // Prescaler and saturating duration counter. The state machine below samples
   // dur_q on the edge cycle; both counters restart so the next interval is
   // measured from this edge.
   always_comb begin
      presc_d = presc_q;
      dur_d   = dur_q;
      if (edge_seen) begin
         presc_d = '0;
         dur_d   = '0;
      end else begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick && (dur_q != DUR_MAX)) begin
            dur_d = dur_q + 11'd1;
         end
      end
   end

   // Frame state machine. Mark states only ever see a rise and space states
   // only a fall, since the edge register alternates. Errors and frame
   // completion are collected in frame_err / frame_done and resolved at the end
   // so that every exit path clears the partial shift register the same way.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      code_d     = code_q;
      have_d     = have_q;
      valid_d    = 1'b0;
      repeat_d   = 1'b0;
      err_d      = 1'b0;
      frame_err  = 1'b0;
      frame_done = 1'b0;

      if (edge_seen) begin
         case (state_q)
            IDLE: begin
               if (fall) begin
                  state_d = LEAD_MARK;
               end
            end
            LEAD_MARK: begin
               if (rise && in_win(dur_q, 11'd800, 11'd1000)) begin
                  state_d = LEAD_SPACE;
               end else begin
                  frame_err = 1'b1;
               end
            end
            LEAD_SPACE: begin
               if (fall && in_win(dur_q, 11'd400, 11'd500)) begin
                  state_d   = BIT_MARK;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end else if (fall && in_win(dur_q, 11'd180, 11'd270)) begin
                  state_d = REP_MARK;
               end else begin
                  frame_err = 1'b1;
               end
            end
            BIT_MARK: begin
               if (rise && in_win(dur_q, 11'd40, 11'd72)) begin
                  if (bit_cnt_q == 6'd32) begin
                     frame_done = 1'b1;
                  end else begin
                     state_d = BIT_SPACE;
                  end
               end else begin
                  frame_err = 1'b1;
               end
            end
            BIT_SPACE: begin
               if (fall && in_win(dur_q, 11'd40, 11'd72)) begin
                  shift_d   = {shift_q[30:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  state_d   = BIT_MARK;
               end else if (fall && in_win(dur_q, 11'd140, 11'd200)) begin
                  shift_d   = {shift_q[30:0], 1'b1};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  state_d   = BIT_MARK;
               end else begin
                  frame_err = 1'b1;
               end
            end
            REP_MARK: begin
               if (rise && in_win(dur_q, 11'd40, 11'd72)) begin
                  state_d  = IDLE;
                  repeat_d = have_q;
               end else begin
                  frame_err = 1'b1;
               end
            end
            default: begin
               frame_err = 1'b1;
            end
         endcase
      end else if ((state_q != IDLE) && (dur_q >= TIMEOUT)) begin
         frame_err = 1'b1;
      end

      // The final stop mark closes the frame; with the integrity option the
      // address/command complement test can still turn it into an error.
      if (frame_done) begin
`ifdef NEC_INTEGRITY_CHECK_EN
         if (shift_q[15:8] == ~shift_q[7:0]) begin
            code_d  = shift_q;
            have_d  = 1'b1;
            valid_d = 1'b1;
         end else begin
            frame_err = 1'b1;
         end
`else
         code_d  = shift_q;
         have_d  = 1'b1;
         valid_d = 1'b1;
`endif
         state_d = IDLE;
      end

      if (frame_err) begin
         state_d   = IDLE;
         err_d     = 1'b1;
         shift_d   = '0;
         bit_cnt_d = '0;
      end
   end

   // All state, including the idle-high synchronizer, in one register bank.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         prev_q    <= 1'b1;
         presc_q   <= '0;
         dur_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         code_q    <= '0;
         have_q    <= 1'b0;
         valid_q   <= 1'b0;
         repeat_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         presc_q   <= presc_d;
         dur_q     <= dur_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         code_q    <= code_d;
         have_q    <= have_d;
         valid_q   <= valid_d;
         repeat_q  <= repeat_d;
         err_q     <= err_d;
      end
   end

   assign code_out   = code_q;
   assign valid_out  = valid_q;
   assign repeat_out = repeat_q;
   assign err_out    = err_q;
   assign busy_out   = (state_q != IDLE);

endmodule

// File: tb/tb_nec_ir_receiver.sv
// tb_nec_ir_receiver
// Drives NEC frames into nec_ir_receiver with a small tick prescaler. Each
// stimulus step pushes the strobe it should cause into a queue; a monitor on
// the falling clock edge pops and compares whenever valid/repeat/err is seen.

module tb_nec_ir_receiver;

   localparam int TICK = 2;

   logic        clk;
   logic        rstN;
   logic        irRaw;
   logic [31:0] codeOut;
   logic        validOut;
   logic        repeatOut;
   logic        errOut;
   logic        busyOut;

   typedef struct {
      int          kind;
      logic [31:0] code;
   } exp_t;

   localparam int K_VALID  = 1;
   localparam int K_REPEAT = 2;
   localparam int K_ERR    = 3;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;

   nec_ir_receiver #(
      .TICK_CYCLES   (TICK),
      .TIMEOUT_TICKS (1200)
   ) dut (
      .clk_in     (clk),
      .rst_in     (rstN),
      .ir_raw_in  (irRaw),
      .code_out   (codeOut),
      .valid_out  (validOut),
      .repeat_out (repeatOut),
      .err_out    (errOut),
      .busy_out   (busyOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value and log a failure line if it differs.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Hold the IR line at one level for a number of ticks.
   task automatic applyStimulus(input logic lvl, input int ticks);
      irRaw = lvl;
      repeat (ticks * TICK) @(negedge clk);
   endtask

   task automatic sendLeaderBits(input logic [31:0] code, input int nbits);
      applyStimulus(1'b0, 900);
      applyStimulus(1'b1, 450);
      for (int i = 0; i < nbits; i++) begin
         applyStimulus(1'b0, 56);
         applyStimulus(1'b1, code[31-i] ? 169 : 56);
      end
      applyStimulus(1'b0, 56);
   endtask

   task automatic sendFrame(input logic [31:0] code);
      sendLeaderBits(code, 32);
      applyStimulus(1'b1, 100);
   endtask

   task automatic sendRepeat();
      applyStimulus(1'b0, 900);
      applyStimulus(1'b1, 225);
      applyStimulus(1'b0, 56);
      applyStimulus(1'b1, 100);
   endtask

   task automatic pushExp(input int kind, input logic [31:0] code);
      exp_t e;
      e.kind = kind;
      e.code = code;
      expQ.push_back(e);
   endtask

   // Bounded wait for every expected strobe to have been consumed.
   task automatic waitDrain(input string name);
      int n = 0;
      while ((expQ.size() != 0) && (n < 400)) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_pending"}, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   task automatic checkIdleOutputs(input string name, input logic [31:0] code);
      checkOutput({name, "_code"}, codeOut, code);
      checkOutput({name, "_valid"}, {31'd0, validOut}, 32'd0);
      checkOutput({name, "_repeat"}, {31'd0, repeatOut}, 32'd0);
      checkOutput({name, "_err"}, {31'd0, errOut}, 32'd0);
      checkOutput({name, "_busy"}, {31'd0, busyOut}, 32'd0);
   endtask

   // Scoreboard monitor: any strobe must match the head of the expected queue,
   // only one strobe may be high, and no strobe may last two cycles.
   logic prevStrobe = 1'b0;
   always @(negedge clk) begin
      int   nStrobe;
      int   kind;
      exp_t e;
      nStrobe = int'(validOut) + int'(repeatOut) + int'(errOut);
      if (nStrobe != 0) begin
         kind = validOut ? K_VALID : (repeatOut ? K_REPEAT : K_ERR);
         checkOutput("strobe_exclusive", 32'(nStrobe), 32'd1);
         checkOutput("strobe_single_cycle", {31'd0, prevStrobe}, 32'd0);
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_strobe actual_kind=%0d required=none code=%h",
                     kind, codeOut);
         end else begin
            e = expQ.pop_front();
            checkOutput("strobe_kind", 32'(kind), 32'(e.kind));
            checkOutput("strobe_code", codeOut, e.code);
         end
      end
      prevStrobe = (nStrobe != 0);
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN  = 1'b0;
      irRaw = 1'b1;
      repeat (4) @(negedge clk);
      checkIdleOutputs("reset", 32'h0);
      rstN = 1'b1;
      applyStimulus(1'b1, 20);

      // Nominal frame.
      pushExp(K_VALID, 32'h20DF5BA4);
      sendFrame(32'h20DF5BA4);
      waitDrain("nominal");
      checkOutput("nominal_busy_after", {31'd0, busyOut}, 32'd0);
      checkOutput("nominal_code_held", codeOut, 32'h20DF5BA4);

      // Repeat frame after a held code.
      pushExp(K_REPEAT, 32'h20DF5BA4);
      sendRepeat();
      waitDrain("repeat");

      // Repeat directly after reset: nothing should be reported.
      rstN = 1'b0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1'b1, 20);
      sendRepeat();
      checkIdleOutputs("repeat_after_reset", 32'h0);

      // Short leader mark, then a good frame.
      pushExp(K_ERR, 32'h0);
      applyStimulus(1'b0, 700);
      applyStimulus(1'b1, 450);
      waitDrain("short_leader");
      checkOutput("short_leader_busy", {31'd0, busyOut}, 32'd0);
      pushExp(K_VALID, 32'h20DF5AA5);
      sendFrame(32'h20DF5AA5);
      waitDrain("after_error");

      // Line held high after bit 10 until the timeout fires.
      sendLeaderBits(32'h20DF5AA5, 10);
      irRaw = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("timeout_busy_before", {31'd0, busyOut}, 32'd1);
      pushExp(K_ERR, 32'h20DF5AA5);
      applyStimulus(1'b1, 1300);
      waitDrain("timeout");
      checkOutput("timeout_busy_after", {31'd0, busyOut}, 32'd0);
      checkOutput("timeout_code", codeOut, 32'h20DF5AA5);

      // Reset during bit 20, then a full frame.
      sendLeaderBits(32'h20DF5AA5, 20);
      applyStimulus(1'b1, 20);
      checkOutput("midreset_busy_before", {31'd0, busyOut}, 32'd1);
      rstN = 1'b0;
      #1;
      checkIdleOutputs("midreset_during", 32'h0);
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1'b1, 100);
      checkIdleOutputs("midreset_release", 32'h0);
      pushExp(K_VALID, 32'h20DF5AA5);
      sendFrame(32'h20DF5AA5);
      waitDrain("after_midreset");

      // Frame whose low byte is not the complement of the byte above it.
`ifdef NEC_INTEGRITY_CHECK_EN
      pushExp(K_ERR, 32'h20DF5AA5);
      sendFrame(32'h20DF5BA5);
      waitDrain("integrity");
      checkOutput("integrity_code", codeOut, 32'h20DF5AA5);
`else
      pushExp(K_VALID, 32'h20DF5BA5);
      sendFrame(32'h20DF5BA5);
      waitDrain("integrity");
      checkOutput("integrity_code", codeOut, 32'h20DF5BA5);
`endif
      checkOutput("final_busy", {31'd0, busyOut}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
